aes_128_encrypt: RTL and testbench
==================================

Name: aes_128_encrypt

Overview:
Fully pipelined AES-128 encryption core (FIPS-197), one 128-bit block per clock. Eleven register stages: the initial AddRoundKey, then rounds 1-10. The key schedule is pipelined alongside the data, so plaintext and key may both change every cycle. It sits as a streaming datapath engine with no handshake; the caller tracks validity by counting 11 cycles.

Parameters:
None. Key size is fixed at 128 bits and the round count is fixed at 10.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; asynchronous, active-high (asserted = 1 despite the name)
plaintext  input  128  input block; bit 127 = byte 0 (FIPS-197 byte order, MSB first)
cipher_key  input  128  cipher key, same byte order; sampled together with plaintext
ciphertext  output  128  encrypted block, registered output of stage 10

Behaviour:
- Reset is asynchronous and active-high, fixed.
  - While rst_n = 1, every state and key pipeline register clears to 0 immediately, without waiting for clk.
  - ciphertext = 128'h0 during reset.
  - Operation resumes on the first rising clk edge after rst_n falls to 0.
- Stage 0 (edge N):
  - state0 <= plaintext ^ cipher_key.
  - key0 <= cipher_key.
- Stage r = 1..9 (edge N+r):
  - rk_r = KeyExpand(key_{r-1}, Rcon[r]).
  - state_r <= MixColumns(ShiftRows(SubBytes(state_{r-1}))) ^ rk_r.
  - key_r <= rk_r.
- Stage 10 (edge N+10):
  - ciphertext <= ShiftRows(SubBytes(state_9)) ^ rk_10, with no MixColumns.
- KeyExpand, with words w0..w3 of the previous key (w0 = bits 127:96):
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex).
- Latency and throughput:
  - Inputs sampled at edge N produce ciphertext valid after edge N+10, i.e. 11 clock edges including the sampling edge.
  - One result per cycle. Independent blocks with different keys flow back-to-back with no interference.
- Arithmetic:
  - SubBytes uses the standard AES S-box, implemented as combinational logic or a case ROM.
  - MixColumns uses GF(2^8) multiplication with polynomial x^8+x^4+x^3+x+1; xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
  - ShiftRows: row r is rotated left by r bytes. State is column-major, byte k = bits 127-8k : 120-8k.
- After reset release, ciphertext shows intermediate pipeline contents for the first 10 edges. These values are not meaningful; the core does not mask them.
- No enable input: the pipeline advances every clock.
- Reset mid-operation flushes all in-flight blocks. After release, results only reappear 11 edges after new inputs are sampled.
- X on the inputs propagates without any protection logic.

Test Plan:
1. Assert rst_n = 1 for 20 ns -> ciphertext = 0 throughout reset, asynchronously, before any clk edge.
2. FIPS-197 C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, sampled at edge N -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a after edge N+10.
3. Zero plaintext, zero key -> ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e 11 edges after sampling.
4. FIPS-197 Appendix B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32.
5. Back-to-back throughput: apply vectors 2, 3 and 4 on three consecutive edges -> the three expected ciphertexts appear on three consecutive cycles, in order, with no bubbles.
6. Reset mid-stream: assert rst_n 5 cycles after applying vector 2 -> ciphertext is 0 at once. Re-apply vector 2 after release -> correct result 11 edges after re-sampling, with no stale output from the flushed blocks.

Source files
------------

// File: rtl/aes_128_encrypt.sv
// Fully pipelined AES-128 encryption: eleven register stages, one block per clock.
// The key schedule travels alongside the data, so every stage carries its own round key.
module aes_128_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] plaintext,
    input  logic [127:0] cipher_key,
    output logic [127:0] ciphertext
);

    // S-box packed so that entry b sits at bits [(255-b)*8 +: 8].
    localparam logic [2047:0] SboxTbl = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] Rcon [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SboxTbl[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows; byte k is row k%4, column k/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = sbox(s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] state_q [10];
    logic [127:0] state_d [10];
    logic [127:0] key_q   [10];
    logic [127:0] key_d   [10];
    logic [127:0] ct_q, ct_d;

    always_comb begin
        state_d[0] = plaintext ^ cipher_key;
        key_d[0]   = cipher_key;
        for (int r = 1; r < 10; r++) begin
            key_d[r]   = key_expand(key_q[r-1], Rcon[r-1]);
            state_d[r] = mix_columns(sub_shift(state_q[r-1])) ^ key_d[r];
        end
        // Final round omits MixColumns.
        ct_d = sub_shift(state_q[9]) ^ key_expand(key_q[9], Rcon[9]);
    end

    // Reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 10; i++) begin
                state_q[i] <= '0;
                key_q[i]   <= '0;
            end
            ct_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
        end
    end

    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_128_encrypt.sv
// Directed bench for aes_128_encrypt: known-answer vectors, latency, throughput and
// asynchronous reset flush.
module tb_aes_128_encrypt;

    localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CtZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         rst_n;
    logic [127:0] plaintext;
    logic [127:0] cipher_key;
    logic [127:0] ciphertext;

    int errors = 0;
    int checks = 0;

    aes_128_encrypt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .plaintext  (plaintext),
        .cipher_key (cipher_key),
        .ciphertext (ciphertext)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
        checks++;
        assert (obs !== bad)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected anything but %h", tag, obs, bad);
        end
    endtask

    // Drive at a falling edge, then look 11 rising edges later.
    task automatic run_vec(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp);
        @(negedge clk);
        plaintext  = pt;
        cipher_key = key;
        repeat (11) @(posedge clk);
        #1 check_eq(tag, ciphertext, exp);
    endtask

    initial begin
        // 1: asynchronous reset before any clock edge, held for 20 ns
        rst_n      = 1'b0;
        plaintext  = '0;
        cipher_key = '0;
        #1 rst_n = 1'b1;
        #1 check_eq("reset_async", ciphertext, 128'h0);
        plaintext  = PtC1;
        cipher_key = KeyC1;
        #18 check_eq("reset_held", ciphertext, 128'h0);
        plaintext  = '0;
        cipher_key = '0;
        #1 rst_n = 1'b0;

        // 2: C.1, plus a look one edge early (shows the zero block sampled just before)
        @(negedge clk);
        plaintext  = PtC1;
        cipher_key = KeyC1;
        repeat (10) @(posedge clk);
        #1 check_eq("c1_edge_n9_zero_block", ciphertext, CtZ);
        @(posedge clk);
        #1 check_eq("c1_result", ciphertext, CtC1);

        // 3 and 4
        run_vec("zero_result", 128'h0, 128'h0, CtZ);
        run_vec("appb_result", PtB, KeyB, CtB);

        // 5: back-to-back, three different keys
        @(negedge clk);
        plaintext  = PtC1;
        cipher_key = KeyC1;
        @(negedge clk);
        plaintext  = 128'h0;
        cipher_key = 128'h0;
        @(negedge clk);
        plaintext  = PtB;
        cipher_key = KeyB;
        repeat (9) @(posedge clk);
        #1 check_eq("b2b_first", ciphertext, CtC1);
        @(posedge clk);
        #1 check_eq("b2b_second", ciphertext, CtZ);
        @(posedge clk);
        #1 check_eq("b2b_third", ciphertext, CtB);

        // 6: reset five cycles into a C.1 block, then re-sample it
        @(negedge clk);
        plaintext  = PtC1;
        cipher_key = KeyC1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check_eq("midreset_immediate", ciphertext, 128'h0);
        @(posedge clk);
        #1 check_eq("midreset_across_edge", ciphertext, 128'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 check_ne($sformatf("flush_no_stale_%0d", i), ciphertext, CtC1);
        end
        @(posedge clk);
        #1 check_eq("flush_resample_result", ciphertext, CtC1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
